// File: rtl/common.vh
// Shared build-time defaults for the CPU7 core.
// CSR address width and CSR write-queue depth.
`ifndef COMMON_VH
`define COMMON_VH
`define LSOC1K_CSR_BIT 14
`define CSR_WRQ_DEPTH 2
`endif

// File: rtl/cpu7_csr_wrq.sv
// CSR pipeline-write FIFO with per-entry address compare.
// Enqueue on a full queue is accepted only when the head leaves.
`include "common.vh"
module cpu7_csr_wrq #(
   parameter int DEPTH = `CSR_WRQ_DEPTH,
   parameter int AW    = `LSOC1K_CSR_BIT,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq,
   input  logic [AW-1:0]    enq_addr,
   input  logic [31:0]      enq_data,
   input  logic             deq,
   input  logic [AW-1:0]    cmp_addr,
   output logic [AW-1:0]    head_addr,
   output logic [31:0]      head_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic [DEPTH-1:0] hit
);
   logic [AW-1:0]    addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             enq_ok;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign enq_ok    = enq && (!full || deq);
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++)
         hit[i] = vld_q[i] && (addr_q[i] == cmp_addr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (deq) begin
            vld_q[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         // set after clear so a full-queue swap keeps the slot valid
         if (enq_ok) begin
            vld_q[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         case ({enq_ok, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq_ok) begin
         addr_q[wr_ptr] <= enq_addr;
         data_q[wr_ptr] <= enq_data;
      end
   end
endmodule

// File: rtl/cpu7_csr_wrarb.sv
// CSR write-port arbiter: pipeline write queue vs hardware updates,
// round-robin on conflict, registered write port and read-hazard hold.
`include "common.vh"
module cpu7_csr_wrarb #(
   parameter int QDEPTH = `CSR_WRQ_DEPTH,
   parameter int CSRW   = `LSOC1K_CSR_BIT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pipe_wr_vld,
   input  logic [CSRW-1:0] pipe_wr_addr,
   input  logic [31:0]     pipe_wr_data,
   input  logic            hw_wr_vld,
   input  logic [CSRW-1:0] hw_wr_addr,
   input  logic [31:0]     hw_wr_data,
   output logic            hw_wr_rdy,
   input  logic [CSRW-1:0] csr_raddr_d,
   output logic            csr_rd_hold,
   output logic            pipe_stall,
   output logic            csr_we,
   output logic [CSRW-1:0] csr_waddr,
   output logic [31:0]     csr_wdata,
   output logic            wrarb_idle,
   output logic            ovf_err
);
   localparam int CW = $clog2(QDEPTH) + 1;

   logic [CSRW-1:0]   q_addr;
   logic [31:0]       q_data;
   logic [CW-1:0]     q_count;
   logic              q_full;
   logic              q_empty;
   logic [QDEPTH-1:0] q_hit;
   logic              grant_q;
   logic              grant_hw;
   logic              last_hw;

   cpu7_csr_wrq #(.DEPTH(QDEPTH), .AW(CSRW)) u_wrq (
      .clk      (clk),
      .reset    (reset),
      .enq      (pipe_wr_vld),
      .enq_addr (pipe_wr_addr),
      .enq_data (pipe_wr_data),
      .deq      (grant_q),
      .cmp_addr (csr_raddr_d),
      .head_addr(q_addr),
      .head_data(q_data),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty),
      .hit      (q_hit)
   );

   // last_hw=1 means the hw side won last, so the queue goes next
   always_comb begin
      grant_q  = 1'b0;
      grant_hw = 1'b0;
      if (!reset) begin
         case ({!q_empty, hw_wr_vld})
            2'b10:   grant_q  = 1'b1;
            2'b01:   grant_hw = 1'b1;
            2'b11: begin
               grant_q  = last_hw;
               grant_hw = !last_hw;
            end
            default: ;
         endcase
      end
   end

   assign hw_wr_rdy  = grant_hw;
   assign pipe_stall = q_full;
   assign wrarb_idle = q_empty && !hw_wr_vld && !csr_we;

   assign csr_rd_hold = (|q_hit)
                     || (hw_wr_vld && (hw_wr_addr == csr_raddr_d))
                     || (csr_we && (csr_waddr == csr_raddr_d));

   always_ff @(posedge clk) begin
      if (reset) begin
         csr_we    <= 1'b0;
         csr_waddr <= '0;
         csr_wdata <= '0;
         last_hw   <= 1'b1;
         ovf_err   <= 1'b0;
      end else begin
         csr_we <= grant_q || grant_hw;
         if (grant_q) begin
            csr_waddr <= q_addr;
            csr_wdata <= q_data;
         end else if (grant_hw) begin
            csr_waddr <= hw_wr_addr;
            csr_wdata <= hw_wr_data;
         end
         if (grant_q || grant_hw)
            last_hw <= grant_hw;
         if (pipe_wr_vld && q_full && !grant_q)
            ovf_err <= 1'b1;
      end
   end
endmodule
